mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory-side stage: posted write buffer with read forwarding and a ready-handshaked RAM port.
// Define MEM_TIMEOUT_EN to abort stalled RAM accesses after TIMEOUT cycles and raise err.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int WBUF_DEPTH = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           mar_addr,
    input  logic [31:0]           mdr_data,
    input  logic                  rd_req,
    input  logic                  wr_req,
    output logic                  wr_ready,
    output logic                  rd_ready,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);
    localparam int PW = $clog2(WBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q [WBUF_DEPTH];
    logic [31:0]           wb_data_q [WBUF_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [PW:0]           cnt_q;
    logic                  rd_pend_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [31:0]           rd_data_q;
    logic                  rd_valid_q;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  full, push, rd_acc, pop, rd_fin, abort;
    logic                  fwd_hit;
    logic [31:0]           fwd_data;
    logic [PW-1:0]         idx;

    assign req_addr = mar_addr[ADDR_WIDTH-1:0];
    assign full     = (cnt_q == (PW+1)'(WBUF_DEPTH));
    assign wr_ready = !full;
    assign rd_ready = !rd_pend_q;
    assign push     = wr_req && wr_ready;
    assign rd_acc   = rd_req && rd_ready;
    assign pop      = (state_q == WRITE) && (mem_ready || abort);
    assign rd_fin   = (state_q == READ) && (mem_ready || abort);
    assign busy     = (cnt_q != '0) || rd_pend_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    assign mem_we    = (state_q == WRITE);
    assign mem_re    = (state_q == READ);
    assign mem_addr  = mem_we ? wb_addr_q[rptr_q] :
                       mem_re ? rd_addr_q : '0;
    assign mem_wdata = mem_we ? wb_data_q[rptr_q] : '0;

    // Scan oldest to youngest so the youngest match wins; a same-cycle write is youngest of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            idx = rptr_q + PW'(i);
            if ((PW+1)'(i) < cnt_q && wb_addr_q[idx] == req_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data_q[idx];
            end
        end
        if (push && req_addr == req_addr && wr_req) begin
            fwd_hit  = 1'b1;
            fwd_data = mdr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0 || push)
                    state_d = WRITE;
                else if (rd_pend_q || (rd_acc && !fwd_hit))
                    state_d = READ;
            end
            WRITE: begin
                if (pop)
                    state_d = (cnt_q > (PW+1)'(1) || push) ? WRITE : IDLE;
            end
            READ: begin
                if (rd_fin)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[wptr_q] <= req_addr;
            wb_data_q[wptr_q] <= mdr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= 1'b0;
            if (push)
                wptr_q <= wptr_q + 1'b1;
            if (pop)
                rptr_q <= rptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (rd_acc) begin
                if (fwd_hit) begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= fwd_data;
                end else begin
                    rd_pend_q <= 1'b1;
                    rd_addr_q <= req_addr;
                end
            end
            if (rd_fin) begin
                rd_pend_q  <= 1'b0;
                rd_valid_q <= 1'b1;
                rd_data_q  <= abort ? 32'hDEADBEEF : mem_rdata;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;

    assign abort = (mem_we || mem_re) && !mem_ready &&
                   (tmo_q == TW'(TIMEOUT - 1));
    assign err   = err_q;

    // Counter restarts at every access boundary, including back-to-back writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (!(mem_we || mem_re) || pop || rd_fin)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + 1'b1;
            if (abort)
                err_q <= 1'b1;
        end
    end
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    logic unused_mar;
    assign unused_mar = ^mar_addr[31:ADDR_WIDTH];

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: bench-side RAM model checks write order, queue checks read data.
// Timeout checks run when MEM_TIMEOUT_EN is defined.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mar_addr = '0;
    logic [31:0] mdr_data = '0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic        wr_ready, rd_ready, rd_valid, busy, err;
    logic [31:0] rd_data;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re, mem_we;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(9), .WBUF_DEPTH(2), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .mar_addr(mar_addr), .mdr_data(mdr_data),
        .rd_req(rd_req), .wr_req(wr_req), .wr_ready(wr_ready),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd [$];
    logic [40:0] exp_wr [$];
    logic [31:0] ram    [512];
    logic [31:0] shadow [512];
    logic [40:0] e;
    logic [31:0] r;
    bit          hold = 1'b0;
    int          wait_n = 0;
    int          acc_cyc = 0;
    int          re_cnt, lat;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RAM responder and scoreboard consumer.
    always @(negedge clk) begin
        if (reset) begin
            acc_cyc   = 0;
            mem_ready = 1'b0;
        end else begin
            if ((mem_re || mem_we) && !hold && acc_cyc >= wait_n) begin
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        check("wr_extra", 32'd1, 32'd0);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", {23'd0, mem_addr}, {23'd0, e[40:32]});
                        check("wr_data", mem_wdata, e[31:0]);
                    end
                    ram[mem_addr] = mem_wdata;
                end
                mem_ready = 1'b1;
                acc_cyc   = 0;
            end else begin
                mem_ready = 1'b0;
                if (mem_re || mem_we)
                    acc_cyc++;
            end
            if (rd_valid) begin
                if (exp_rd.size() == 0) begin
                    check("rd_extra", 32'd1, 32'd0);
                end else begin
                    r = exp_rd.pop_front();
                    check("rd_data", rd_data, r);
                end
            end
        end
        mem_rdata = ram[mem_addr];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d, bit acc);
        mar_addr = a;
        mdr_data = d;
        wr_req   = 1'b1;
        if (acc) begin
            exp_wr.push_back({a[8:0], d});
            shadow[a[8:0]] = d;
        end
        cyc();
        wr_req = 1'b0;
    endtask

    task automatic rd(logic [31:0] a, logic [31:0] exp);
        mar_addr = a;
        rd_req   = 1'b1;
        exp_rd.push_back(exp);
        cyc();
        rd_req = 1'b0;
    endtask

    task automatic wait_idle(string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
        cyc();
    endtask

    // Counts strobe cycles and cycles until rd_valid after a read was issued.
    task automatic rd_track(int limit, output int res_re, output int res_lat);
        res_re  = 0;
        res_lat = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (mem_re)
                res_re++;
            if (rd_valid) begin
                res_lat = i + 1;
                break;
            end
        end
        cyc();
    endtask

    task automatic idle_checks(string tag);
        @(negedge clk);
        check({tag, "_re"}, mem_re, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_wrdy"}, wr_ready, 1);
        check({tag, "_rrdy"}, rd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rdata"}, rd_data, 0);
        check({tag, "_err"}, err, 0);
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i]    = '0;
            shadow[i] = '0;
        end
        ram[16]    = 32'hA5A5A5A5;
        shadow[16] = 32'hA5A5A5A5;

        repeat (2) cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_addr", {23'd0, mem_addr}, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_valid", rd_valid, 0);
        cyc();
        idle_checks("rst");

        // Reset while a write is stalled on the RAM port.
        hold = 1'b1;
        wr(32'h40, 32'h1, 1'b1);
        @(negedge clk);
        check("we_pre_rst", mem_we, 1);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_wr.delete();
        shadow[64] = '0;
        hold = 1'b0;
        idle_checks("midrst");

        // Single write, address upper bits truncated.
        wr(32'h200, 32'hCAFEF00D, 1'b1);
        @(negedge clk);
        check("w1_we", mem_we, 1);
        check("w1_addr", {23'd0, mem_addr}, 0);
        check("w1_wdata", mem_wdata, 32'hCAFEF00D);
        cyc();
        @(negedge clk);
        check("w1_busy", busy, 0);
        check("w1_we_off", mem_we, 0);
        cyc();

        // Fill buffer, third write ignored, in-order drain.
        hold = 1'b1;
        wr(32'h1, 32'hA1, 1'b1);
        wr(32'h2, 32'hA2, 1'b1);
        @(negedge clk);
        check("full_wrdy", wr_ready, 0);
        cyc();
        wr(32'h3, 32'hA3, 1'b0);
        @(negedge clk);
        check("full_wrdy2", wr_ready, 0);
        check("full_head", {23'd0, mem_addr}, 32'h1);
        cyc();
        hold = 1'b0;
        wait_idle("drain_full");
        check("wr_q_empty", exp_wr.size(), 0);
        check("ignored_wr", ram[3], 0);

        // Forward from buffer while RAM stalls.
        hold = 1'b1;
        wr(32'h5, 32'h1234, 1'b1);
        rd(32'h5, 32'h1234);
        @(negedge clk);
        check("fwd_valid", rd_valid, 1);
        check("fwd_no_re", mem_re, 0);
        cyc();
        hold = 1'b0;
        wait_idle("drain_fwd");

        // Same-cycle write and read: read sees the write.
        hold = 1'b1;
        mar_addr = 32'h7;
        mdr_data = 32'h77;
        wr_req = 1'b1;
        rd_req = 1'b1;
        exp_wr.push_back({9'h7, 32'h77});
        shadow[7] = 32'h77;
        exp_rd.push_back(32'h77);
        cyc();
        wr_req = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        check("same_valid", rd_valid, 1);
        cyc();
        hold = 1'b0;
        wait_idle("drain_same");

        // Youngest of two matching entries wins.
        hold = 1'b1;
        wr(32'h8, 32'h1, 1'b1);
        wr(32'h8, 32'h2, 1'b1);
        rd(32'h8, 32'h2);
        @(negedge clk);
        check("young_valid", rd_valid, 1);
        cyc();
        hold = 1'b0;
        wait_idle("drain_young");

        // Minimum read-miss latency through RAM.
        wait_n = 0;
        wr(32'h30, 32'hBEEF, 1'b1);
        wait_idle("drain_30");
        rd(32'h30, shadow[48]);
        rd_track(20, re_cnt, lat);
        check("min_re", re_cnt, 1);
        check("min_lat", lat, 2);

        // Read miss with three wait states.
        wait_n = 3;
        rd(32'h10, 32'hA5A5A5A5);
        rd_track(20, re_cnt, lat);
        check("wait_re", re_cnt, 4);
        check("wait_lat", lat, 5);
        cyc();
        @(negedge clk);
        check("rdata_hold", rd_data, 32'hA5A5A5A5);
        check("valid_pulse", rd_valid, 0);
        cyc();
        wait_n = 0;

`ifdef MEM_TIMEOUT_EN
        hold = 1'b1;
        rd(32'h20, 32'hDEADBEEF);
        rd_track(40, re_cnt, lat);
        check("tmo_re", re_cnt, 16);
        check("tmo_lat", lat, 17);
        check("tmo_err", err, 1);
        repeat (3) cyc();
        @(negedge clk);
        check("tmo_sticky", err, 1);
        cyc();
        hold = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("tmo_clr", err, 0);
        cyc();
`endif

        check("rd_q_empty", exp_rd.size(), 0);
        check("wr_q_left", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
